// File: rtl/univ_reg_if.sv
// Request/response bundle for the univ_reg working register.
// The master drives the operation request and the slave returns register status.
interface univ_reg_if #(
   parameter int unsigned W  = 8,
   parameter int unsigned AW = 3
);
   logic          EN;
   logic [2:0]    OP;
   logic [W-1:0]  D;
   logic          SI;
   logic [AW-1:0] AMT;
   logic [W-1:0]  Q;
   logic          SO;
   logic          CO;
   logic          Z;
   logic          BUSY;
   logic          DONE;

   modport master (
      output EN, OP, D, SI, AMT,
      input  Q, SO, CO, Z, BUSY, DONE
   );

   modport slave (
      input  EN, OP, D, SI, AMT,
      output Q, SO, CO, Z, BUSY, DONE
   );
endinterface

// File: rtl/univ_reg.sv
// Multi-mode W-bit working register: load, single shifts, inc/dec and
// multi-cycle shift-left / rotate-right by a programmable amount.
module univ_reg #(
   parameter int unsigned   W       = 8,
   parameter logic [W-1:0]  RST_VAL = '0,
   parameter int unsigned   AW      = 3
) (
   input logic        C,
   input logic        R,
   univ_reg_if.slave  bus
);
   localparam logic [2:0] OP_HOLD = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_SHL1 = 3'b010;
   localparam logic [2:0] OP_SHR1 = 3'b011;
   localparam logic [2:0] OP_INC  = 3'b100;
   localparam logic [2:0] OP_DEC  = 3'b101;
   localparam logic [2:0] OP_SHLN = 3'b110;
   localparam logic [2:0] OP_RORN = 3'b111;

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state, state_n;
   logic [W-1:0]  q, q_n;
   logic          so, so_n;
   logic          co, co_n;
   logic          busy, busy_n;
   logic          done, done_n;
   logic          rot, rot_n;
   logic [AW-1:0] cnt, cnt_n;

   logic [W-1:0]  step_q;
   logic          step_so;
   logic          step_rot;
   logic [W:0]    inc_sum;

   // One step of the multi-cycle op; the op kind is latched once RUN is entered.
   always_comb begin
      step_rot = (state == RUN) ? rot : bus.OP[0];
      if (step_rot) begin
         step_q  = {q[0], q[W-1:1]};
         step_so = q[0];
      end else begin
         step_q  = {q[W-2:0], bus.SI};
         step_so = q[W-1];
      end
   end

   assign inc_sum = {1'b0, q} + (W+1)'(1);

   always_ff @(posedge C or negedge R) begin
      if (!R) begin
         state <= IDLE;
         q     <= RST_VAL;
         so    <= 1'b0;
         co    <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         rot   <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         q     <= q_n;
         so    <= so_n;
         co    <= co_n;
         busy  <= busy_n;
         done  <= done_n;
         rot   <= rot_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      q_n     = q;
      so_n    = so;
      co_n    = co;
      rot_n   = rot;
      cnt_n   = cnt;
      done_n  = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.EN) begin
               case (bus.OP)
                  OP_HOLD: begin
                  end
                  OP_LOAD: q_n = bus.D;
                  OP_SHL1: begin
                     q_n  = {q[W-2:0], bus.SI};
                     so_n = q[W-1];
                  end
                  OP_SHR1: begin
                     q_n  = {bus.SI, q[W-1:1]};
                     so_n = q[0];
                  end
                  OP_INC: begin
                     q_n  = inc_sum[W-1:0];
                     co_n = inc_sum[W];
                  end
                  OP_DEC: begin
                     q_n  = q - W'(1);
                     co_n = (q == '0);
                  end
                  OP_SHLN, OP_RORN: begin
                     rot_n = bus.OP[0];
                     // Amounts 0 and 1 finish on the accept edge without entering RUN.
                     if (bus.AMT == '0) begin
                        done_n = 1'b1;
                     end else begin
                        q_n  = step_q;
                        so_n = step_so;
                        if (bus.AMT == AW'(1)) begin
                           done_n = 1'b1;
                        end else begin
                           cnt_n   = bus.AMT - AW'(1);
                           state_n = RUN;
                        end
                     end
                  end
               endcase
            end
         end
         RUN: begin
            q_n   = step_q;
            so_n  = step_so;
            cnt_n = cnt - AW'(1);
            if (cnt == AW'(1)) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
      endcase
      busy_n = (state_n == RUN);
   end

   assign bus.Q    = q;
   assign bus.SO   = so;
   assign bus.CO   = co;
   assign bus.BUSY = busy;
   assign bus.DONE = done;
   assign bus.Z    = (q == '0);
endmodule

// File: tb/tb_univ_reg.sv
// Self-checking bench for univ_reg (W=8, RST_VAL=A5, AW=3): directed scenarios
// followed by randomized operations checked against a transaction-level model.
module tb_univ_reg;
   localparam int unsigned W  = 8;
   localparam int unsigned AW = 3;

   logic C = 1'b0;
   logic R = 1'b0;
   always #5 C = ~C;

   univ_reg_if #(.W(W), .AW(AW)) bus ();

   univ_reg #(.W(W), .RST_VAL(8'hA5), .AW(AW)) dut (
      .C   (C),
      .R   (R),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] m_q;
   logic       m_so;
   logic       m_co;

   task automatic tick();
      @(posedge C);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [7:0] d, input logic si,
                        input logic [2:0] amt);
      bus.EN  = 1'b1;
      bus.OP  = op;
      bus.D   = d;
      bus.SI  = si;
      bus.AMT = amt;
      tick();
      bus.EN  = 1'b0;
   endtask

   // Shift left by k with a constant fill bit.
   function automatic logic [7:0] f_shl(input logic [7:0] q, input logic si, input int k);
      if (k >= 8) return {8{si}};
      return 8'((int'(q) << k) | (si ? ((1 << k) - 1) : 0));
   endfunction

   function automatic logic [7:0] f_ror(input logic [7:0] q, input int k);
      int kk;
      kk = k % 8;
      return 8'((int'(q) >> kk) | (int'(q) << (8 - kk)));
   endfunction

   task automatic test_reset();
      bus.EN = 1'b0; bus.OP = 3'b000; bus.D = 8'h00; bus.SI = 1'b0; bus.AMT = 3'd0;
      R = 1'b0;
      #12;
      n_cmp++;
      if ({bus.Q, bus.SO, bus.CO, bus.BUSY, bus.DONE, bus.Z} !== {8'hA5, 5'b00000}) begin
         n_bad++;
         $display("FAIL reset_initial: got Q=%h SO=%b CO=%b B=%b D=%b Z=%b, want Q=a5 rest 0",
                  bus.Q, bus.SO, bus.CO, bus.BUSY, bus.DONE, bus.Z);
      end
      R = 1'b1;
      tick();
      issue(3'b001, 8'h00, 1'b0, 3'd0);
      n_cmp++;
      if ({bus.Q, bus.Z} !== {8'h00, 1'b1}) begin
         n_bad++;
         $display("FAIL reset_preload: got Q=%h Z=%b, want Q=00 Z=1", bus.Q, bus.Z);
      end
      // Asynchronous reset well away from any clock edge.
      #3 R = 1'b0;
      #1;
      n_cmp++;
      if ({bus.Q, bus.SO, bus.CO, bus.BUSY, bus.DONE, bus.Z} !== {8'hA5, 5'b00000}) begin
         n_bad++;
         $display("FAIL reset_async: got Q=%h SO=%b CO=%b B=%b D=%b Z=%b, want Q=a5 rest 0",
                  bus.Q, bus.SO, bus.CO, bus.BUSY, bus.DONE, bus.Z);
      end
      R = 1'b1;
      tick();
   endtask

   task automatic test_load_incdec();
      logic [7:0] eq [5];
      logic       ec [5];
      logic [2:0] ops [5];
      ops = '{3'b001, 3'b100, 3'b101, 3'b101, 3'b000};
      eq  = '{8'hFF, 8'h00, 8'hFF, 8'hFE, 8'hFE};
      ec  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) begin
         issue(ops[i], 8'hFF, 1'b1, 3'd0);
         n_cmp++;
         if ({bus.Q, bus.CO, bus.Z, bus.SO, bus.BUSY, bus.DONE} !==
             {eq[i], ec[i], (eq[i] == 8'h00), 3'b000}) begin
            n_bad++;
            $display("FAIL incdec_%0d: got Q=%h CO=%b Z=%b SO=%b B=%b D=%b, want Q=%h CO=%b",
                     i, bus.Q, bus.CO, bus.Z, bus.SO, bus.BUSY, bus.DONE, eq[i], ec[i]);
         end
      end
   endtask

   task automatic test_single_shift();
      issue(3'b001, 8'h81, 1'b0, 3'd0);
      issue(3'b010, 8'h00, 1'b0, 3'd0);
      n_cmp++;
      if ({bus.Q, bus.SO, bus.CO} !== {8'h02, 1'b1, 1'b0}) begin
         n_bad++;
         $display("FAIL shl1: got Q=%h SO=%b CO=%b, want Q=02 SO=1 CO=0", bus.Q, bus.SO, bus.CO);
      end
      issue(3'b011, 8'h00, 1'b1, 3'd0);
      n_cmp++;
      if ({bus.Q, bus.SO, bus.CO} !== {8'h81, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL shr1: got Q=%h SO=%b CO=%b, want Q=81 SO=0 CO=0", bus.Q, bus.SO, bus.CO);
      end
   endtask

   task automatic test_rotate_multi();
      logic [7:0] eq [3];
      logic       es [3];
      logic       eb [3];
      eq = '{8'h80, 8'h40, 8'h20};
      es = '{1'b1, 1'b0, 1'b0};
      eb = '{1'b1, 1'b1, 1'b0};
      issue(3'b001, 8'h01, 1'b0, 3'd0);
      issue(3'b111, 8'h00, 1'b0, 3'd3);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({bus.Q, bus.SO, bus.BUSY, bus.DONE} !== {eq[i], es[i], eb[i], (i == 2)}) begin
            n_bad++;
            $display("FAIL rot_step%0d: got Q=%h SO=%b B=%b D=%b, want Q=%h SO=%b B=%b D=%b",
                     i, bus.Q, bus.SO, bus.BUSY, bus.DONE, eq[i], es[i], eb[i], (i == 2));
         end
         // A load presented while busy must be ignored.
         if (i < 2) begin
            bus.EN = (i < 1); bus.OP = 3'b001; bus.D = 8'h00;
            tick();
            bus.EN = 1'b0;
         end
      end
      tick();
      n_cmp++;
      if ({bus.Q, bus.BUSY, bus.DONE} !== {8'h20, 2'b00}) begin
         n_bad++;
         $display("FAIL rot_after: got Q=%h B=%b D=%b, want Q=20 B=0 D=0", bus.Q, bus.BUSY, bus.DONE);
      end
   endtask

   task automatic test_zero_one_amt();
      issue(3'b001, 8'h0F, 1'b0, 3'd0);
      issue(3'b110, 8'h00, 1'b1, 3'd0);
      n_cmp++;
      if ({bus.Q, bus.SO, bus.BUSY, bus.DONE} !== {8'h0F, 1'b0, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL amt0: got Q=%h SO=%b B=%b D=%b, want Q=0f SO=0 B=0 D=1",
                  bus.Q, bus.SO, bus.BUSY, bus.DONE);
      end
      tick();
      n_cmp++;
      if ({bus.BUSY, bus.DONE} !== 2'b00) begin
         n_bad++;
         $display("FAIL amt0_after: got B=%b D=%b, want 0 0", bus.BUSY, bus.DONE);
      end
      issue(3'b110, 8'h00, 1'b1, 3'd1);
      n_cmp++;
      if ({bus.Q, bus.SO, bus.BUSY, bus.DONE} !== {8'h1F, 1'b0, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL amt1: got Q=%h SO=%b B=%b D=%b, want Q=1f SO=0 B=0 D=1",
                  bus.Q, bus.SO, bus.BUSY, bus.DONE);
      end
      tick();
      n_cmp++;
      if ({bus.BUSY, bus.DONE} !== 2'b00) begin
         n_bad++;
         $display("FAIL amt1_after: got B=%b D=%b, want 0 0", bus.BUSY, bus.DONE);
      end
   endtask

   // SI is sampled on every step of a multi-cycle shift.
   task automatic test_live_si();
      issue(3'b001, 8'h00, 1'b0, 3'd0);
      issue(3'b110, 8'h00, 1'b1, 3'd3);
      bus.SI = 1'b0;
      tick();
      bus.SI = 1'b1;
      tick();
      n_cmp++;
      if ({bus.Q, bus.SO, bus.BUSY, bus.DONE} !== {8'h05, 1'b0, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL live_si: got Q=%h SO=%b B=%b D=%b, want Q=05 SO=0 B=0 D=1",
                  bus.Q, bus.SO, bus.BUSY, bus.DONE);
      end
   endtask

   task automatic test_abort();
      issue(3'b001, 8'h3C, 1'b0, 3'd0);
      issue(3'b110, 8'h00, 1'b0, 3'd7);
      tick();
      tick();
      n_cmp++;
      if ({bus.Q, bus.BUSY} !== {8'hE0, 1'b1}) begin
         n_bad++;
         $display("FAIL abort_step3: got Q=%h B=%b, want Q=e0 B=1", bus.Q, bus.BUSY);
      end
      #3 R = 1'b0;
      #1;
      n_cmp++;
      if ({bus.Q, bus.SO, bus.CO, bus.BUSY, bus.DONE, bus.Z} !== {8'hA5, 5'b00000}) begin
         n_bad++;
         $display("FAIL abort_reset: got Q=%h SO=%b CO=%b B=%b D=%b Z=%b, want Q=a5 rest 0",
                  bus.Q, bus.SO, bus.CO, bus.BUSY, bus.DONE, bus.Z);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         n_cmp++;
         if ({bus.Q, bus.BUSY, bus.DONE} !== {8'hA5, 2'b00}) begin
            n_bad++;
            $display("FAIL abort_hold%0d: got Q=%h B=%b D=%b, want Q=a5 B=0 D=0",
                     i, bus.Q, bus.BUSY, bus.DONE);
         end
      end
      R = 1'b1;
      issue(3'b001, 8'h5A, 1'b0, 3'd0);
      n_cmp++;
      if ({bus.Q, bus.BUSY, bus.DONE} !== {8'h5A, 2'b00}) begin
         n_bad++;
         $display("FAIL abort_reload: got Q=%h B=%b D=%b, want Q=5a", bus.Q, bus.BUSY, bus.DONE);
      end
   endtask

   // Random requests, issued back to back (including on the DONE cycle).
   task automatic test_random();
      logic [2:0] op;
      logic [7:0] d;
      logic       si;
      logic [2:0] amt;
      int         k;
      m_q = 8'h5A; m_so = 1'b0; m_co = 1'b0;
      for (int n = 0; n < 300; n++) begin
         op  = 3'($urandom_range(0, 7));
         d   = 8'($urandom);
         si  = 1'($urandom);
         amt = 3'($urandom);
         k   = int'(amt);
         case (op)
            3'b001: m_q = d;
            3'b010: begin m_so = m_q[7]; m_q = {m_q[6:0], si}; end
            3'b011: begin m_so = m_q[0]; m_q = {si, m_q[7:1]}; end
            3'b100: begin m_co = (m_q == 8'hFF); m_q = 8'(m_q + 8'd1); end
            3'b101: begin m_co = (m_q == 8'h00); m_q = 8'(m_q - 8'd1); end
            3'b110: if (k > 0) begin m_so = m_q[8 - k]; m_q = f_shl(m_q, si, k); end
            3'b111: if (k > 0) begin m_so = m_q[(k - 1) % 8]; m_q = f_ror(m_q, k); end
            default: ;
         endcase
         issue(op, d, si, amt);
         if (op >= 3'b110) begin
            for (int c = 1; c < k; c++) begin
               n_cmp++;
               if ({bus.BUSY, bus.DONE} !== 2'b10) begin
                  n_bad++;
                  $display("FAIL rnd_busy n=%0d op=%0d k=%0d c=%0d: got B=%b D=%b, want 1 0",
                           n, op, k, c, bus.BUSY, bus.DONE);
               end
               tick();
            end
         end
         n_cmp++;
         if ({bus.Q, bus.SO, bus.CO, bus.Z, bus.BUSY, bus.DONE} !==
             {m_q, m_so, m_co, (m_q == 8'h00), 1'b0, (op >= 3'b110)}) begin
            n_bad++;
            $display("FAIL rnd n=%0d op=%0d amt=%0d: got Q=%h SO=%b CO=%b Z=%b B=%b D=%b, want Q=%h SO=%b CO=%b D=%b",
                     n, op, amt, bus.Q, bus.SO, bus.CO, bus.Z, bus.BUSY, bus.DONE,
                     m_q, m_so, m_co, (op >= 3'b110));
         end
         if ($urandom_range(0, 3) == 0) begin
            tick();
            n_cmp++;
            if ({bus.Q, bus.SO, bus.CO, bus.BUSY, bus.DONE} !== {m_q, m_so, m_co, 2'b00}) begin
               n_bad++;
               $display("FAIL rnd_idle n=%0d: got Q=%h SO=%b CO=%b B=%b D=%b, want Q=%h SO=%b CO=%b",
                        n, bus.Q, bus.SO, bus.CO, bus.BUSY, bus.DONE, m_q, m_so, m_co);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_incdec();
      test_single_shift();
      test_rotate_multi();
      test_zero_one_amt();
      test_live_si();
      test_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
